n101_deglitch_ctrl: RTL and testbench



---
 rtl/n101_deglitch_ctrl.sv | 151 +++++++++++++++
 tb/tb_n101_deglitch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_deglitch_ctrl.sv
// Debounce controller for always-on input pins: sync, prescaled sampling, N-sample qualify.
// Optional macro N101_DEGLITCH_FALL_IRQ_EN: committed falls also raise io_irq.
module n101_deglitch_ctrl #(
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_d,
    input  logic               io_en,
    input  logic [PRESC_W-1:0] io_presc,
    input  logic [CNT_W-1:0]   io_thresh,
    input  logic               io_irq_clr,
    output logic               io_q,
    output logic               io_rise,
    output logic               io_fall,
    output logic               io_irq,
    output logic               io_busy
);

`ifdef N101_DEGLITCH_FALL_IRQ_EN
    localparam logic FALL_IRQ = 1'b1;
`else
    localparam logic FALL_IRQ = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        STABLE   = 2'd1,
        QUALIFY  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               s1;
    logic               s2;
    logic [PRESC_W-1:0] pcnt;
    logic               tick;
    logic [CNT_W-1:0]   rcnt;
    logic [CNT_W-1:0]   rcnt_n;
    logic [CNT_W-1:0]   rcnt_inc;
    logic [CNT_W-1:0]   t_eff;
    logic               commit;
    logic               q_n;
    logic               rise_n;
    logic               fall_n;
    logic               irq_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= io_d;
            s2 <= s1;
        end
    end

    // >= lets a shrunk period take effect on the very next cycle
    assign tick = io_en && (pcnt >= io_presc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!io_en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

    assign t_eff    = (io_thresh == '0) ? CNT_ONE : io_thresh;
    assign rcnt_inc = (&rcnt) ? rcnt : rcnt + CNT_ONE;

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        q_n     = io_q;
        commit  = 1'b0;
        if (!io_en) begin
            state_n = DISABLED;
            rcnt_n  = '0;
        end else begin
            unique case (state)
                DISABLED: begin
                    state_n = STABLE;
                    q_n     = s2;
                    rcnt_n  = '0;
                end
                STABLE: begin
                    if (tick && (s2 != io_q)) begin
                        if (t_eff == CNT_ONE) begin
                            commit = 1'b1;
                        end else begin
                            state_n = QUALIFY;
                            rcnt_n  = CNT_ONE;
                        end
                    end
                end
                QUALIFY: begin
                    if (tick) begin
                        if (s2 == io_q) begin
                            state_n = STABLE;
                            rcnt_n  = '0;
                        end else if (rcnt_inc >= t_eff) begin
                            commit = 1'b1;
                        end else begin
                            rcnt_n = rcnt_inc;
                        end
                    end
                end
                default: begin
                    state_n = DISABLED;
                    rcnt_n  = '0;
                end
            endcase
        end
        if (commit) begin
            q_n     = ~io_q;
            state_n = STABLE;
            rcnt_n  = '0;
        end
        rise_n = commit & ~io_q;
        fall_n = commit & io_q;
        // a set in the same cycle as a clear wins
        irq_n  = rise_n | (FALL_IRQ & fall_n) | (io_irq & ~io_irq_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= DISABLED;
            rcnt    <= '0;
            io_q    <= 1'b0;
            io_rise <= 1'b0;
            io_fall <= 1'b0;
            io_irq  <= 1'b0;
        end else begin
            state   <= state_n;
            rcnt    <= rcnt_n;
            io_q    <= q_n;
            io_rise <= rise_n;
            io_fall <= fall_n;
            io_irq  <= irq_n;
        end
    end

    assign io_busy = (state == QUALIFY);

endmodule

// File: tb/tb_n101_deglitch_ctrl.sv
// Directed bench for n101_deglitch_ctrl: expectations are queued per cycle
// and compared by a monitor one time unit after each rising edge.
module tb_n101_deglitch_ctrl;

`ifdef N101_DEGLITCH_FALL_IRQ_EN
    localparam logic FI = 1'b1;
`else
    localparam logic FI = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        io_d;
    logic        io_en;
    logic [15:0] io_presc;
    logic [3:0]  io_thresh;
    logic        io_irq_clr;
    logic        io_q;
    logic        io_rise;
    logic        io_fall;
    logic        io_irq;
    logic        io_busy;

    typedef struct {
        string      tag;
        int         c;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    n101_deglitch_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .io_d       (io_d),
        .io_en      (io_en),
        .io_presc   (io_presc),
        .io_thresh  (io_thresh),
        .io_irq_clr (io_irq_clr),
        .io_q       (io_q),
        .io_rise    (io_rise),
        .io_fall    (io_fall),
        .io_irq     (io_irq),
        .io_busy    (io_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [4:0] obs();
        return {io_q, io_rise, io_fall, io_irq, io_busy};
    endfunction

    task automatic check(string tag, logic [4:0] got, logic [4:0] want);
        n_chk++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: q/rise/fall/irq/busy got %b want %b", tag, got, want);
        end
    endtask

    task automatic expv(string tag, int c, logic [4:0] v);
        exp_t e;
        e.tag = tag;
        e.c   = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic ne(int n);
        repeat (n) @(negedge clock);
    endtask

    // scoreboard monitor
    always @(posedge clock) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            if (e.c != cyc) begin
                n_chk++;
                assert (e.c == cyc) else begin
                    n_err++;
                    $error("FAIL %s: checked at cycle %0d want cycle %0d", e.tag, cyc, e.c);
                end
            end else begin
                check(e.tag, obs(), e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset      = 1'b1;
        io_en      = 1'b0;
        io_d       = 1'b1;
        io_presc   = 16'd0;
        io_thresh  = 4'd3;
        io_irq_clr = 1'b0;

        ne(1);
        k = cyc;
        expv("reset", k + 1, 5'b00000);
        ne(2);
        reset = 1'b0;
        ne(3);

        // resync onto a high pin without pulse or irq
        k = cyc;
        io_en = 1'b1;
        expv("resync", k + 1, 5'b10000);
        expv("resync_hold", k + 2, 5'b10000);
        ne(3);

        // clean fall, presc=0, thresh=3
        k = cyc;
        io_d = 1'b0;
        expv("fall_sync", k + 2, 5'b10000);
        expv("fall_qual1", k + 3, 5'b10001);
        expv("fall_qual2", k + 4, 5'b10001);
        expv("fall_commit", k + 5, {3'b001, FI, 1'b0});
        expv("fall_once", k + 6, {3'b000, FI, 1'b0});
        ne(6);
        k = cyc;
        io_irq_clr = 1'b1;
        expv("fall_clr", k + 1, 5'b00000);
        ne(1);
        io_irq_clr = 1'b0;
        ne(1);

        // clean rise, presc=0, thresh=3
        k = cyc;
        io_d = 1'b1;
        expv("rise_sync", k + 2, 5'b00000);
        expv("rise_qual1", k + 3, 5'b00001);
        expv("rise_qual2", k + 4, 5'b00001);
        expv("rise_commit", k + 5, 5'b11010);
        expv("rise_once", k + 6, 5'b10010);
        ne(6);
        k = cyc;
        io_irq_clr = 1'b1;
        expv("rise_clr", k + 1, 5'b10000);
        ne(1);
        io_irq_clr = 1'b0;
        ne(1);

        // thresh=0 acts as 1
        io_thresh = 4'd0;
        k = cyc;
        io_d = 1'b0;
        expv("t0_wait", k + 2, 5'b10000);
        expv("t0_commit", k + 3, {3'b001, FI, 1'b0});
        expv("t0_once", k + 4, {3'b000, FI, 1'b0});
        ne(4);
        io_irq_clr = 1'b1;
        ne(1);
        io_irq_clr = 1'b0;
        ne(1);

        // clear coinciding with a rise commit loses, next cycle clears
        k = cyc;
        io_d = 1'b1;
        expv("set_wins", k + 3, 5'b11010);
        expv("clr_next", k + 4, 5'b10000);
        ne(2);
        io_irq_clr = 1'b1;
        ne(2);
        io_irq_clr = 1'b0;

        // back to q=0 with thresh=1
        io_thresh = 4'd1;
        k = cyc;
        io_d = 1'b0;
        expv("t1_fall", k + 3, {3'b001, FI, 1'b0});
        ne(4);
        io_irq_clr = 1'b1;
        ne(1);
        io_irq_clr = 1'b0;
        ne(1);

        // glitch rejection: presc=3, thresh=4, 10-cycle high pulse
        k = cyc;
        io_presc  = 16'd3;
        io_thresh = 4'd4;
        io_d      = 1'b1;
        for (int i = 1; i <= 17; i++)
            expv("glitch", k + i, {4'b0000, (i >= 4 && i <= 15)});
        ne(10);
        io_d = 1'b0;
        ne(8);

        // abort while qualifying, then silent re-enable
        io_presc = 16'd0;
        k = cyc;
        io_d = 1'b1;
        expv("abort_pre", k + 2, 5'b00000);
        expv("abort_busy1", k + 3, 5'b00001);
        expv("abort_busy2", k + 4, 5'b00001);
        expv("abort", k + 5, 5'b00000);
        expv("abort_hold", k + 6, 5'b00000);
        ne(4);
        io_en = 1'b0;
        ne(2);
        k = cyc;
        io_en = 1'b1;
        expv("reenable", k + 1, 5'b10000);
        expv("reenable_hold", k + 2, 5'b10000);
        ne(2);

        // prescaler shrink 100 -> 2 with pcnt at 50
        io_thresh = 4'd1;
        k = cyc;
        io_presc = 16'd100;
        ne(40);
        io_d = 1'b0;
        expv("shrink_wait", k + 50, 5'b10000);
        ne(10);
        io_presc = 16'd2;
        expv("shrink_tick", k + 51, {3'b001, FI, 1'b0});
        ne(1);
        io_d = 1'b1;
        expv("shrink_notick", k + 53, {3'b000, FI, 1'b0});
        expv("shrink_tick2", k + 54, 5'b11010);
        ne(3);
        io_d = 1'b0;
        expv("shrink_notick2", k + 56, 5'b10010);
        expv("shrink_tick3", k + 57, 5'b00110);
        ne(4);

        // asynchronous reset mid-operation
        reset = 1'b1;
        #1;
        check("async_reset", obs(), 5'b00000);
        ne(2);
        reset = 1'b0;
        ne(2);

        n_chk++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain: got %0d pending want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
